// File: rtl/systolic_seq_pkg.sv
// Shared types and helpers for the systolic array operand sequencer.
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // Matrix dimension selected by a size code: N = 2^(code+1).
    function automatic int unsigned size_decode(input int unsigned code);
        return 32'(1) << (code + 1);
    endfunction

    // Cycles for the last operand wavefront to reach the far corner of the array.
    function automatic int unsigned drain_len(input int unsigned n, input int unsigned arr_lat);
        return 3 * (n - 1) + arr_lat;
    endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Control, operand-buffer and array-feed signals of the systolic sequencer.
interface systolic_sequencer_if #(
    parameter int unsigned SIZE   = 32,
    parameter int unsigned I_BITS = 8,
    parameter int unsigned CODE_W = 3
);
    logic                     i_start;
    logic [CODE_W-1:0]        i_size_code;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_err;
    logic                     o_rd_en;
    logic [$clog2(SIZE)-1:0]  o_rd_addr;
    logic [SIZE*I_BITS-1:0]   i_a_col;
    logic [SIZE*I_BITS-1:0]   i_b_row;
    logic                     o_arr_valid;
    logic                     o_arr_clear;
    logic [SIZE*I_BITS-1:0]   o_arr_a;
    logic [SIZE*I_BITS-1:0]   o_arr_b;

    modport master (
        output i_start, i_size_code, i_a_col, i_b_row,
        input  o_busy, o_done, o_err, o_rd_en, o_rd_addr,
               o_arr_valid, o_arr_clear, o_arr_a, o_arr_b
    );

    modport slave (
        input  i_start, i_size_code, i_a_col, i_b_row,
        output o_busy, o_done, o_err, o_rd_en, o_rd_addr,
               o_arr_valid, o_arr_clear, o_arr_a, o_arr_b
    );
endinterface

// File: rtl/systolic_sequencer_operand_skew.sv
// Triangular delay line: lane i is delayed i cycles, lane 0 passes straight through.
module operand_skew #(
    parameter int unsigned LANES = 32,
    parameter int unsigned W     = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [LANES*W-1:0] i_lanes,
    output logic [LANES*W-1:0] o_lanes
);

    assign o_lanes[W-1:0] = i_lanes[W-1:0];

    for (genvar i = 1; i < LANES; i++) begin : g_lane
        logic [W-1:0] sr [i];

        always_ff @(posedge i_clock) begin
            if (!i_reset) begin
                for (int j = 0; j < i; j++) sr[j] <= '0;
            end else begin
                sr[0] <= i_lanes[i*W +: W];
                for (int j = 1; j < i; j++) sr[j] <= sr[j-1];
            end
        end

        assign o_lanes[i*W +: W] = sr[i-1];
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Self-timed controller: clears the array, reads N operand columns/rows,
// skews them into the diagonal wavefront and reports completion after drain.
module systolic_sequencer #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned I_BITS  = 8,
    parameter int unsigned ARR_LAT = 1,
    parameter int unsigned CODE_W  = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    systolic_sequencer_if.slave  bus
);
    import systolic_seq_pkg::*;

    localparam int unsigned AW = $clog2(SIZE);
    localparam int unsigned NW = AW + 1;
    localparam int unsigned DW = $clog2(3 * SIZE + ARR_LAT + 1);
    localparam int unsigned LW = SIZE * I_BITS;

    seq_state_e      state;
    logic [NW-1:0]   n_q;
    logic [DW-1:0]   drain_cnt;
    logic [DW-1:0]   valid_cnt;
    logic            busy_q, done_q, err_q, rd_en_q, valid_q, clear_q;
    logic [AW-1:0]   rd_addr_q;
    logic            data_ret_q;
    logic            code_ok_c;
    logic [LW-1:0]   a_in, b_in;

    assign code_ok_c = (32'(bus.i_size_code) < AW);

    // Sequencer FSM with registered outputs; valid window runs alongside FEED/DRAIN.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            n_q        <= '0;
            drain_cnt  <= '0;
            valid_cnt  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            valid_q    <= 1'b0;
            clear_q    <= 1'b0;
            data_ret_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clear_q    <= 1'b0;
            data_ret_q <= rd_en_q;

            if (valid_q) begin
                if (valid_cnt == '0) valid_q   <= 1'b0;
                else                 valid_cnt <= valid_cnt - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (code_ok_c) begin
                            n_q     <= NW'(size_decode(32'(bus.i_size_code)));
                            state   <= ST_CLEAR;
                            clear_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    state     <= ST_FEED;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                end
                ST_FEED: begin
                    // First read's data returns next cycle: open the 2N-1 valid window.
                    if (rd_addr_q == '0) begin
                        valid_q   <= 1'b1;
                        valid_cnt <= DW'((32'(n_q) << 1) - 2);
                    end
                    if (rd_addr_q == AW'(n_q - 1'b1)) begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        drain_cnt <= DW'(drain_len(32'(n_q), ARR_LAT) - 1);
                        state     <= ST_DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Skew input: only returned data on lanes below N, zeros otherwise.
    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int unsigned r = 0; r < SIZE; r++) begin
            if (data_ret_q && (r < 32'(n_q))) begin
                a_in[r*I_BITS +: I_BITS] = bus.i_a_col[r*I_BITS +: I_BITS];
                b_in[r*I_BITS +: I_BITS] = bus.i_b_row[r*I_BITS +: I_BITS];
            end
        end
    end

    operand_skew #(.LANES(SIZE), .W(I_BITS)) u_skew_a (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_lanes (a_in),
        .o_lanes (bus.o_arr_a)
    );

    operand_skew #(.LANES(SIZE), .W(I_BITS)) u_skew_b (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_lanes (b_in),
        .o_lanes (bus.o_arr_b)
    );

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_rd_en     = rd_en_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_arr_valid = valid_q;
    assign bus.o_arr_clear = clear_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: timing, skew, errors, reset and back-to-back runs.
module tb_systolic_sequencer;

    localparam int unsigned SIZE    = 32;
    localparam int unsigned I_BITS  = 8;
    localparam int unsigned ARR_LAT = 1;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned LW      = SIZE * I_BITS;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    systolic_sequencer_if #(.SIZE(SIZE), .I_BITS(I_BITS), .CODE_W(CODE_W)) bus ();

    systolic_sequencer #(
        .SIZE(SIZE), .I_BITS(I_BITS), .ARR_LAT(ARR_LAT), .CODE_W(CODE_W)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    // Operand buffer: A[r][k] = 16r+k, B[k][c] = 0x40+4k+c, one cycle after the read; junk when idle.
    logic [LW-1:0] a_v, b_v;
    always @(posedge clk) begin
        if (bus.o_rd_en) begin
            for (int r = 0; r < int'(SIZE); r++) begin
                a_v[r*I_BITS +: I_BITS] = I_BITS'(16 * r + int'(bus.o_rd_addr));
                b_v[r*I_BITS +: I_BITS] = I_BITS'(8'h40 + 4 * int'(bus.o_rd_addr) + r);
            end
        end else begin
            a_v = '1;
            b_v = '1;
        end
        bus.i_a_col <= a_v;
        bus.i_b_row <= b_v;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [I_BITS-1:0] lane(input logic [LW-1:0] v, input int i);
        return v[i*I_BITS +: I_BITS];
    endfunction

    function automatic logic [I_BITS-1:0] exp_a(input int r, input int t, input int n);
        int k = t - 3 - r;
        return (r < n && k >= 0 && k < n) ? I_BITS'(16 * r + k) : '0;
    endfunction

    function automatic logic [I_BITS-1:0] exp_b(input int c, input int t, input int n);
        int k = t - 3 - c;
        return (c < n && k >= 0 && k < n) ? I_BITS'(8'h40 + 4 * k + c) : '0;
    endfunction

    // One complete run started at cycle 0 from IDLE, checked cycle by cycle.
    task automatic check_run(input int code);
        int n  = 1 << (code + 1);
        int td = n + 2 + 3 * (n - 1) + int'(ARR_LAT);
        logic [LW-1:0] hi_a, hi_b;
        bus.i_size_code = CODE_W'(code);
        bus.i_start     = 1'b1;
        for (int t = 0; t <= td + 1; t++) begin
            if (t == 1) bus.i_start = 1'b0;
            check($sformatf("busy n=%0d t=%0d", n, t),  64'(bus.o_busy),      64'(t >= 1 && t <= td));
            check($sformatf("clear n=%0d t=%0d", n, t), 64'(bus.o_arr_clear), 64'(t == 1));
            check($sformatf("done n=%0d t=%0d", n, t),  64'(bus.o_done),      64'(t == td));
            check($sformatf("valid n=%0d t=%0d", n, t), 64'(bus.o_arr_valid), 64'(t >= 3 && t <= 2 * n + 1));
            check($sformatf("rd_en n=%0d t=%0d", n, t), 64'(bus.o_rd_en),     64'(t >= 2 && t <= n + 1));
            check($sformatf("err n=%0d t=%0d", n, t),   64'(bus.o_err),       64'(0));
            if (t >= 2 && t <= n + 1)
                check($sformatf("rd_addr n=%0d t=%0d", n, t), 64'(bus.o_rd_addr), 64'(t - 2));
            check($sformatf("a_l0 n=%0d t=%0d", n, t),  64'(lane(bus.o_arr_a, 0)),     64'(exp_a(0, t, n)));
            check($sformatf("a_l2 n=%0d t=%0d", n, t),  64'(lane(bus.o_arr_a, 2)),     64'(exp_a(2, t, n)));
            check($sformatf("a_ln n=%0d t=%0d", n, t),  64'(lane(bus.o_arr_a, n - 1)), 64'(exp_a(n - 1, t, n)));
            check($sformatf("b_l1 n=%0d t=%0d", n, t),  64'(lane(bus.o_arr_b, 1)),     64'(exp_b(1, t, n)));
            check($sformatf("b_ln n=%0d t=%0d", n, t),  64'(lane(bus.o_arr_b, n - 1)), 64'(exp_b(n - 1, t, n)));
            if (n < int'(SIZE)) begin
                hi_a = bus.o_arr_a >> (n * int'(I_BITS));
                hi_b = bus.o_arr_b >> (n * int'(I_BITS));
                check($sformatf("a_hi_zero n=%0d t=%0d", n, t), 64'(hi_a == '0), 64'(1));
                check($sformatf("b_hi_zero n=%0d t=%0d", n, t), 64'(hi_b == '0), 64'(1));
            end
            step();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},  64'(bus.o_busy),      64'(0));
        check({tag, " done"},  64'(bus.o_done),      64'(0));
        check({tag, " err"},   64'(bus.o_err),       64'(0));
        check({tag, " rd_en"}, 64'(bus.o_rd_en),     64'(0));
        check({tag, " addr"},  64'(bus.o_rd_addr),   64'(0));
        check({tag, " valid"}, 64'(bus.o_arr_valid), 64'(0));
        check({tag, " clear"}, 64'(bus.o_arr_clear), 64'(0));
        check({tag, " a0"},    64'(bus.o_arr_a == '0), 64'(1));
        check({tag, " b0"},    64'(bus.o_arr_b == '0), 64'(1));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_size_code = '0;
        step();
        step();
        check_quiet("reset");
        rst_n = 1'b1;
        step();

        // Nominal N=4 run.
        check_run(1);

        // Illegal size code: single err pulse, nothing else moves.
        bus.i_size_code = CODE_W'(5);
        bus.i_start     = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            check($sformatf("ill err t=%0d", t),   64'(bus.o_err),   64'(t == 1));
            check($sformatf("ill busy t=%0d", t),  64'(bus.o_busy),  64'(0));
            check($sformatf("ill rd_en t=%0d", t), 64'(bus.o_rd_en), 64'(0));
            step();
        end

        // Reset asserted during cycle 4 of an N=4 run, then a clean restart at cycle 6.
        bus.i_size_code = CODE_W'(1);
        bus.i_start     = 1'b1;
        step();
        bus.i_start = 1'b0;
        step();
        step();
        step();
        check("mid busy t=4", 64'(bus.o_rd_en), 64'(1));
        rst_n = 1'b0;
        step();
        check_quiet("mid_reset t=5");
        rst_n = 1'b1;
        step();
        check_run(1);

        // Start held high: runs separated by exactly one IDLE cycle.
        bus.i_size_code = CODE_W'(1);
        bus.i_start     = 1'b1;
        for (int t = 0; t <= 33; t++) begin
            check($sformatf("b2b clear t=%0d", t), 64'(bus.o_arr_clear), 64'(t == 1 || t == 18));
            check($sformatf("b2b busy t=%0d", t),  64'(bus.o_busy),      64'((t >= 1 && t <= 16) || (t >= 18 && t <= 33)));
            check($sformatf("b2b done t=%0d", t),  64'(bus.o_done),      64'(t == 16 || t == 33));
            step();
        end
        bus.i_start = 1'b0;
        step();
        check("b2b idle busy", 64'(bus.o_busy), 64'(0));
        step();

        // Full-size N=32 run.
        check_run(4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
Control and operand-feed sequencer for the systolic_processorVCounter matrix-multiply array. On a start request it latches the matrix size, issues one accumulator-clear cycle, and reads N operand columns of A and N operand rows of B from external operand buffers. It skews the operands into the array's diagonal wavefront, waits out the array drain latency, and signals completion.
It replaces bench-driven valid/reset/operand stimulus with a self-timed controller.

Parameters:
SIZE, 32, physical array dimension (power of two, 2..32)
I_BITS, 8, operand element width
ARR_LAT, 1, array internal pipeline latency in cycles added to drain
CODE_W, 3, width of size-select code

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-low
i_start  in  1  request a multiply; sampled only in IDLE
i_size_code  in  CODE_W  matrix size select, N = 2^(code+1)
o_busy  out  1  high from CLEAR through DONE inclusive
o_done  out  1  one-cycle pulse, result on array output is final
o_err  out  1  one-cycle pulse, start refused for illegal size code
o_rd_en  out  1  operand buffer read strobe
o_rd_addr  out  $clog2(SIZE)  operand index k (A column k, B row k)
i_a_col  in  SIZE*I_BITS  buffer data, lane r = A[r][k], returned 1 cycle after o_rd_en
i_b_row  in  SIZE*I_BITS  buffer data, lane c = B[k][c], returned 1 cycle after o_rd_en
o_arr_valid  out  1  drives array i_valid
o_arr_clear  out  1  accumulator clear strobe to array
o_arr_a  out  SIZE*I_BITS  skewed A lanes to array i_a_full
o_arr_b  out  SIZE*I_BITS  skewed B lanes to array i_b_full

Behaviour:
- Reset (i_reset=0 at a clock edge): FSM to IDLE. All outputs 0. Skew registers flushed to 0. Counters cleared. Applies mid-operation with no completion pulse.
- Legal code: 2^(code+1) <= SIZE (codes 0..4 for SIZE=32).
- FSM states:
  - IDLE: if i_start and code legal, latch N and go to CLEAR. If i_start and code illegal, o_err=1 for one cycle and stay in IDLE.
  - CLEAR: 1 cycle, o_arr_clear=1, then FEED.
  - FEED: N cycles, o_rd_en=1, o_rd_addr=k=0..N-1, then DRAIN.
  - DRAIN: 3(N-1)+ARR_LAT cycles, no reads, then DONE.
  - DONE: 1 cycle, o_done=1, then IDLE.
- Timing, with start accepted at cycle 0: CLEAR at cycle 1; FEED at cycles 2..N+1; DRAIN from N+2; DONE at cycle N+2+3(N-1)+ARR_LAT.
- i_start while busy is ignored; no queueing. The size code is ignored after latching.
- Feed path: buffer data returns 1 cycle after the read and enters the skew unit.
  - Lanes r >= N are forced to 0 at skew input.
  - A lane r is delayed r cycles; B lane c is delayed c cycles; lane 0 has no delay.
  - Zeros are injected into the skew input whenever no read data returns.
- o_arr_valid: high for 2N-1 consecutive cycles, from the first returned data (cycle 3) through cycle N+2+(N-1). Otherwise 0.
- o_arr_clear and o_arr_valid are never high in the same cycle.
- Counters are sized for SIZE; comparisons use the latched N, so there is no wrap-around past N-1.

Decomposition:
- Package systolic_seq_pkg holds:
  - FSM state encoding (IDLE, CLEAR, FEED, DRAIN, DONE);
  - size-code decode function code -> N;
  - drain-length function 3(N-1)+ARR_LAT.
- Sub-module operand_skew: a SIZE-lane triangular delay line (lane i delay i), instantiated once each for A and B, with a synchronous active-low flush on i_reset.

Test Plan:
- N=4 (code 1), ARR_LAT=1, start at cycle 0. Required response:
  - o_arr_clear at cycle 1; o_rd_addr 0,1,2,3 at cycles 2..5;
  - o_arr_valid at cycles 3..9; o_done at cycle 16 only;
  - o_busy at cycles 1..16.
- Skew check with N=4, A[r][k]=16r+k: o_arr_a lane 2 shows 0x20,0x21,0x22,0x23 at cycles 5..8, and 0 elsewhere. Lanes 4..31 are 0 throughout.
- Full-size run, code 4 (N=32), with the result compared against a golden C matrix: zero-XOR mismatch on o_c_full sampled at o_done.
- Illegal code 5 with i_start=1: o_err=1 for exactly one cycle, o_busy stays 0, no o_rd_en.
- i_reset=0 at cycle 4 of an N=4 run: next cycle all outputs 0 and state IDLE. A new start at cycle 6 completes a normal run with no residue on the skew lanes.
- i_start held high across a whole run: back-to-back runs separated by exactly one IDLE cycle, and the second run's CLEAR follows that IDLE.
